apb_master_nch: RTL and testbench
=================================

APB_MASTER_NCH -- requirements
Module: apb_master_nch

Interface
REQ-001 SHALL have parameter NSLV, default 4, number of APB slave ports (1..16).
REQ-002 SHALL have parameter AW, default 32, APB address width.
REQ-003 SHALL have parameter DW, default 32, APB data width.
REQ-004 SHALL have parameter TMO, default 255, ACCESS-phase timeout in cycles; 0 disables the timeout.
REQ-005 SHALL have a port clk, input, 1 bit: the single clock.
REQ-006 SHALL have a port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have a port en, input, 1 bit: master enable.
REQ-008 SHALL have cmd_valid (in, 1), cmd_ready (out, 1), cmd_write (in, 1), cmd_sel (in, $clog2(NSLV) or 1 if NSLV=1), cmd_addr (in, AW) and cmd_wdata (in, DW): the command request channel.
REQ-009 SHALL have rsp_valid (out, 1), rsp_ready (in, 1), rsp_rdata (out, DW), rsp_err (out, 1) and rsp_tmo (out, 1): the response channel.
REQ-010 SHALL have psel (out, NSLV) and penable (out, NSLV): per-slave select and enable.
REQ-011 SHALL have pwrite (out, 1), paddr (out, AW) and pwdata (out, DW): shared broadcast APB signals.
REQ-012 SHALL have prdata (in, NSLV*DW, slave i at bits [i*DW +: DW]), pready (in, NSLV) and pslverr (in, NSLV).
REQ-013 SHALL have busy (out, 1), high whenever state is not IDLE, and state_o (out, 2), the encoded current state.

Function
REQ-014 The FSM SHALL have four states, encoded IDLE=0, SETUP=1, ACCESS=2, RESP=3.
REQ-015 cmd_ready SHALL be high iff en=1 and state=IDLE; no other state accepts commands.
REQ-016 On cmd_valid & cmd_ready, the block SHALL register write, sel, addr and wdata, and SHALL go to SETUP on the next cycle.
REQ-017 If the accepted cmd_sel >= NSLV, the block SHALL skip the APB transfer and go directly to RESP with rsp_err=1, rsp_tmo=0, rsp_rdata=0.
REQ-018 In SETUP, psel[sel] SHALL be 1 and all penable bits 0; SETUP SHALL last exactly one cycle, then go to ACCESS.
REQ-019 In ACCESS, psel[sel]=1 and penable[sel]=1; all other psel/penable bits SHALL be 0 in every state.
REQ-020 paddr and pwrite SHALL equal the registered values, stable from SETUP through the last ACCESS cycle; pwdata SHALL be 0 on reads.
REQ-021 In ACCESS with pready[sel]=1, the block SHALL capture rsp_rdata = prdata slice sel on reads (0 on writes) and rsp_err = pslverr[sel], and go to RESP.
REQ-022 pready and pslverr of unselected slaves SHALL be ignored.
REQ-023 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without pready[sel].
REQ-024 When TMO≠0 and the counter reaches TMO with pready[sel] low, the block SHALL go to RESP with rsp_err=1, rsp_tmo=1, rsp_rdata=0.
REQ-025 If pready arrives in the same cycle as the timeout, pready SHALL win.
REQ-026 In RESP, rsp_valid=1 and the response fields SHALL stay stable until rsp_ready; on rsp_valid & rsp_ready the block SHALL go to IDLE.
REQ-027 Minimum latency with a zero-wait slave SHALL be: accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3.
REQ-028 Deasserting en SHALL block new commands only; an in-flight transfer SHALL complete through RESP without being aborted.

Reset
REQ-029 On rst_n low, state SHALL be IDLE and psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_tmo, busy, state_o and the wait counter SHALL all be 0, asynchronously.
REQ-030 Reset asserted mid-transfer SHALL drop the transfer and SHALL NOT produce a response after reset releases.

Structure
REQ-031 Package apb_master_pkg SHALL hold the state enum type and the default values of NSLV, AW, DW and TMO.
REQ-032 The timeout SHALL be a sub-module apb_tmo_cnt (inputs clr, inc; output expired; parameter TMO).

Verification
REQ-033 Zero-wait write: NSLV=4, sel=2, addr=0x100, wdata=0xA5A5A5A5 -> psel=4'b0100 in SETUP, penable=4'b0100 for one cycle, rsp_valid at cycle 3, rsp_err=0.
REQ-034 Read with 3 wait states: sel=1, prdata1=0x12345678 -> ACCESS lasts 4 cycles, rsp_rdata=0x12345678.
REQ-035 pslverr: sel=0, pready=1 and pslverr=1 -> rsp_err=1, rsp_tmo=0.
REQ-036 Timeout: TMO=8, slave 3 never ready -> RESP after 8 ACCESS cycles, rsp_err=1, rsp_tmo=1, psel=0 afterwards.
REQ-037 Backpressure and enable: rsp_ready held low for 5 cycles -> response stable and cmd_ready=0; en dropped during ACCESS -> transfer completes and the next cmd_valid is not accepted.
REQ-038 Reset mid-ACCESS -> all outputs 0 immediately and no rsp_valid after release.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types and parameter defaults for the multi-channel APB master.
package apb_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

   localparam int NSLV_DEF = 4;
   localparam int AW_DEF   = 32;
   localparam int DW_DEF   = 32;
   localparam int TMO_DEF  = 255;

endpackage

// File: rtl/apb_tmo_cnt.sv
// ACCESS-phase wait counter; expired flags the cycle in which the TMO-th wait would be spent.
module apb_tmo_cnt #(
   parameter int TMO = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // Saturate so a disabled timeout (TMO=0) never wraps back through zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (TMO != 0) && inc && !clr && (cnt_q == CW'(TMO - 1));

endmodule

// File: rtl/apb_master_nch.sv
// APB master fanning one command channel out to NSLV slave ports.
//   state  | meaning
//   IDLE   | waiting for a command (cmd_ready when en)
//   SETUP  | psel[sel] high, penable low, one cycle
//   ACCESS | psel/penable[sel] high until pready[sel] or timeout
//   RESP   | rsp_valid high, fields held until rsp_ready
module apb_master_nch
   import apb_master_pkg::*;
#(
   parameter  int NSLV = NSLV_DEF,
   parameter  int AW   = AW_DEF,
   parameter  int DW   = DW_DEF,
   parameter  int TMO  = TMO_DEF,
   localparam int SW   = (NSLV > 1) ? $clog2(NSLV) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_write,
   input  logic [SW-1:0]      cmd_sel,
   input  logic [AW-1:0]      cmd_addr,
   input  logic [DW-1:0]      cmd_wdata,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DW-1:0]      rsp_rdata,
   output logic               rsp_err,
   output logic               rsp_tmo,
   output logic [NSLV-1:0]    psel,
   output logic [NSLV-1:0]    penable,
   output logic               pwrite,
   output logic [AW-1:0]      paddr,
   output logic [DW-1:0]      pwdata,
   input  logic [NSLV*DW-1:0] prdata,
   input  logic [NSLV-1:0]    pready,
   input  logic [NSLV-1:0]    pslverr,
   output logic               busy,
   output logic [1:0]         state_o
);

   apb_state_e    state_q, state_d;
   logic          write_q, write_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          tmo_q, tmo_d;

   logic          sel_ready, sel_err, cmd_bad, tmo_expired;
   logic [DW-1:0] sel_rdata;

   // Only the selected slave's handshake is ever looked at.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      psel      = '0;
      penable   = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (sel_q == SW'(i)) begin
            sel_ready  = pready[i];
            sel_err    = pslverr[i];
            sel_rdata  = prdata[i*DW +: DW];
            psel[i]    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
            penable[i] = (state_q == ST_ACCESS);
         end
      end
   end

   assign cmd_bad = int'(cmd_sel) >= NSLV;

   apb_tmo_cnt #(.TMO(TMO)) u_tmo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state_q != ST_ACCESS),
      .inc     ((state_q == ST_ACCESS) && !sel_ready),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               write_d = cmd_write;
               sel_d   = cmd_sel;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               rdata_d = '0;
               err_d   = cmd_bad;
               tmo_d   = 1'b0;
               state_d = cmd_bad ? ST_RESP : ST_SETUP;
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            // pready takes priority over a timeout landing in the same cycle.
            if (sel_ready) begin
               rdata_d = write_q ? '0 : sel_rdata;
               err_d   = sel_err;
               tmo_d   = 1'b0;
               state_d = ST_RESP;
            end else if (tmo_expired) begin
               rdata_d = '0;
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         write_q <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   assign cmd_ready = en && (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign rsp_tmo   = tmo_q;
   assign pwrite    = write_q;
   assign paddr     = addr_q;
   assign pwdata    = write_q ? wdata_q : '0;
   assign busy      = (state_q != ST_IDLE);
   assign state_o   = state_q;

endmodule

// File: tb/tb_apb_master_nch.sv
// Directed vector bench for apb_master_nch (NSLV=4, TMO=8).
module tb_apb_master_nch;

   localparam int NSLV = 4;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int TMO  = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               en = 1'b0;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic               cmd_write = 1'b0;
   logic [1:0]         cmd_sel = '0;
   logic [AW-1:0]      cmd_addr = '0;
   logic [DW-1:0]      cmd_wdata = '0;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic [DW-1:0]      rsp_rdata;
   logic               rsp_err, rsp_tmo;
   logic [NSLV-1:0]    psel, penable;
   logic               pwrite;
   logic [AW-1:0]      paddr;
   logic [DW-1:0]      pwdata;
   logic [NSLV*DW-1:0] prdata = '0;
   logic [NSLV-1:0]    pready = '0;
   logic [NSLV-1:0]    pslverr = '0;
   logic               busy;
   logic [1:0]         state_o;

   apb_master_nch #(.NSLV(NSLV), .AW(AW), .DW(DW), .TMO(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .busy(busy), .state_o(state_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        write;
      logic [1:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] slv_rdata;
      int          waits;      // ACCESS cycles before pready[sel] rises
      logic        slverr;
      int          hold;       // cycles rsp_ready stays low in RESP
      logic        drop_en;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_tmo;
      int          exp_acc;
   } vec_t;

   vec_t vecs[7];

   task automatic do_xfer(input vec_t v);
      int acc;
      logic [3:0] m;
      m = 4'b0001 << v.sel;
      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = v.write; cmd_sel = v.sel;
      cmd_addr = v.addr; cmd_wdata = v.wdata;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_write = ~v.write;
      chk("setup_state", state_o, 1);
      chk("setup_psel", psel, m);
      chk("setup_penable", penable, 0);
      chk("setup_paddr", paddr, v.addr);
      chk("setup_pwrite", pwrite, v.write);
      chk("setup_pwdata", pwdata, v.write ? v.wdata : 32'h0);
      chk("setup_cmd_ready", cmd_ready, 0);
      chk("setup_busy", busy, 1);
      @(negedge clk);
      acc = 0;
      while (state_o == 2'd2 && acc < 20) begin
         acc++;
         if (v.drop_en && acc == 1) en = 1'b0;
         chk("access_psel", psel, m);
         chk("access_penable", penable, m);
         chk("access_paddr", paddr, v.addr);
         chk("access_pwdata", pwdata, v.write ? v.wdata : 32'h0);
         for (int i = 0; i < NSLV; i++) prdata[i*DW +: DW] = 32'hBAD0_0000 | i;
         prdata[v.sel*DW +: DW] = v.slv_rdata;
         pready  = ~m | ((acc > v.waits) ? m : 4'b0);
         pslverr = ~m | (v.slverr ? m : 4'b0);
         @(negedge clk);
      end
      pready = '0; pslverr = '0; prdata = '0;
      chk("access_cycles", acc, v.exp_acc);
      chk("resp_state", state_o, 3);
      chk("resp_valid", rsp_valid, 1);
      chk("resp_rdata", rsp_rdata, v.exp_rdata);
      chk("resp_err", rsp_err, v.exp_err);
      chk("resp_tmo", rsp_tmo, v.exp_tmo);
      chk("resp_psel", psel, 0);
      chk("resp_penable", penable, 0);
      for (int h = 0; h < v.hold; h++) begin
         cmd_valid = 1'b1; cmd_sel = v.sel + 2'd1;
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_rdata", rsp_rdata, v.exp_rdata);
         chk("hold_err", rsp_err, v.exp_err);
         chk("hold_tmo", rsp_tmo, v.exp_tmo);
         chk("hold_cmd_ready", cmd_ready, 0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("done_state", state_o, 0);
      chk("done_valid", rsp_valid, 0);
      chk("done_busy", busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          wr    sel    addr        wdata         slv_rdata     waits slverr hold drop  exp_rdata     err   tmo   acc
      vecs[0] = '{1'b1, 2'd2, 32'h100, 32'hA5A5A5A5, 32'h0,         0,   1'b0, 0,   1'b0, 32'h0,         1'b0, 1'b0, 1};
      vecs[1] = '{1'b0, 2'd1, 32'h204, 32'h0,         32'h12345678, 3,   1'b0, 5,   1'b0, 32'h12345678, 1'b0, 1'b0, 4};
      vecs[2] = '{1'b0, 2'd0, 32'h008, 32'h0,         32'hDEADBEEF, 0,   1'b1, 0,   1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1};
      vecs[3] = '{1'b0, 2'd3, 32'h3FC, 32'h0,         32'h11111111, 100, 1'b0, 1,   1'b0, 32'h0,         1'b1, 1'b1, 8};
      vecs[4] = '{1'b1, 2'd1, 32'h040, 32'h0BADCAFE, 32'h0,         2,   1'b0, 0,   1'b0, 32'h0,         1'b0, 1'b0, 3};
      vecs[5] = '{1'b0, 2'd2, 32'h210, 32'h0,         32'hCAFEF00D, 7,   1'b0, 0,   1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 8};
      vecs[6] = '{1'b1, 2'd3, 32'h0F0, 32'h55AA55AA, 32'h99999999, 1,   1'b1, 2,   1'b1, 32'h0,         1'b1, 1'b0, 2};

      repeat (2) @(negedge clk);
      chk("rst_state", state_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      rst_n = 1'b1;
      en    = 1'b1;

      foreach (vecs[k]) do_xfer(vecs[k]);

      // en was dropped mid-ACCESS by the last vector: nothing new may start.
      for (int c = 0; c < 3; c++) begin
         cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_addr = 32'h777;
         @(negedge clk);
         chk("en_off_cmd_ready", cmd_ready, 0);
         chk("en_off_state", state_o, 0);
         chk("en_off_psel", psel, 0);
      end
      cmd_valid = 1'b0;
      en = 1'b1;

      // Reset asserted during ACCESS.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = 2'd1;
      cmd_addr = 32'h55; cmd_wdata = 32'h77;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_state", state_o, 2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_state", state_o, 0);
      chk("mid_rst_psel", psel, 0);
      chk("mid_rst_penable", penable, 0);
      chk("mid_rst_pwrite", pwrite, 0);
      chk("mid_rst_paddr", paddr, 0);
      chk("mid_rst_pwdata", pwdata, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_tmo}, 0);
      chk("mid_rst_rdata", rsp_rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pready = 4'hF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_rst_valid", rsp_valid, 0);
         chk("post_rst_state", state_o, 0);
      end
      pready = '0;

      do_xfer(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
